// File: rtl/bp_update_ctrl.sv
// -----------------------------------------------------------------------------
// bp_update_ctrl
//
// Sequences every write into the branch predictor tables (BTB and 2-bit PHT).
// Resolved branches from execute are queued in a small FIFO. Each queued update
// performs a read-modify-write of its PHT counter over the shared table port.
// Fetch lookups take priority on that port. After reset or a clear request,
// every table entry is swept back to its initial value.
//
// Optional feature: define BP_UPDATE_STATS_EN to add the statistics counters
// stat_update_count and stat_mispredict_count.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   clear_req          one-cycle pulse: drop queued updates and re-initialise
//   upd_*              resolved-branch handshake and payload from execute
//   fetch_lookup       fetch owns the table port this cycle
//   busy               table initialisation sweep in progress
//   tbl_re/tbl_rdata   PHT read strobe; the counter returns one cycle later
//   tbl_index          table address for the current strobe
//   tbl_btb_*          BTB write enable and write data
//   tbl_pht_*          PHT write enable and write data
//   stat_*             (BP_UPDATE_STATS_EN only) update and mispredict counts
// -----------------------------------------------------------------------------
module bp_update_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  clear_req,
  input  logic                                  upd_valid,
  output logic                                  upd_ready,
  input  logic [ADDR_WIDTH-1:0]                 upd_pc,
  input  logic                                  upd_taken,
  input  logic [ADDR_WIDTH-1:0]                 upd_target,
  input  logic                                  upd_mispredicted,
  input  logic                                  fetch_lookup,
  output logic                                  busy,
  output logic                                  tbl_re,
  input  logic [1:0]                            tbl_rdata,
  output logic [INDEX_WIDTH-1:0]                tbl_index,
  output logic                                  tbl_btb_we,
  output logic                                  tbl_btb_valid,
  output logic [ADDR_WIDTH-INDEX_WIDTH-3:0]     tbl_btb_tag,
  output logic [ADDR_WIDTH-1:0]                 tbl_btb_target,
`ifdef BP_UPDATE_STATS_EN
  output logic [31:0]                           stat_update_count,
  output logic [31:0]                           stat_mispredict_count,
`endif
  output logic                                  tbl_pht_we,
  output logic [1:0]                            tbl_pht_counter
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int PCH_W = ADDR_WIDTH - 2;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

  localparam logic [PTR_W-1:0]       PTR_ONE  = 1;
  localparam logic [PTR_W:0]         CNT_ONE  = 1;
  localparam logic [PTR_W:0]         CNT_FULL = (PTR_W+1)'(QUEUE_DEPTH);
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE
  } state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic [1:0]             rdata_q, rdata_d;

  // FIFO keeps pc[ADDR_WIDTH-1:2]; the byte offset never reaches the tables.
  logic [PCH_W-1:0]       fifo_pc_q  [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_tgt_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] fifo_tkn_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         count_q;

  logic                   fifo_full, fifo_empty;
  logic                   push, pop;
  logic                   sweep_last;
  logic [PCH_W-1:0]       head_pc;
  logic [INDEX_WIDTH-1:0] head_index;
  logic [TAG_W-1:0]       head_tag;
  logic [ADDR_WIDTH-1:0]  head_target;
  logic                   head_taken;
  logic [1:0]             ctr_next;

  logic                   unused_pc_lo;
  assign unused_pc_lo = ^upd_pc[1:0];

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign upd_ready  = !fifo_full && (state_q != S_INIT);
  assign push       = upd_valid && upd_ready && !clear_req;
  assign sweep_last = &sweep_q;

  assign head_pc     = fifo_pc_q[rd_ptr_q];
  assign head_index  = head_pc[INDEX_WIDTH-1:0];
  assign head_tag    = head_pc[PCH_W-1:INDEX_WIDTH];
  assign head_target = fifo_tgt_q[rd_ptr_q];
  assign head_taken  = fifo_tkn_q[rd_ptr_q];

  // Saturating 2-bit counter update from the value captured in WAIT.
  always_comb begin
    if (head_taken) begin
      ctr_next = (rdata_q == 2'b11) ? 2'b11 : rdata_q + 2'b01;
    end else begin
      ctr_next = (rdata_q == 2'b00) ? 2'b00 : rdata_q - 2'b01;
    end
  end

  // FIFO payload storage; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= upd_pc[ADDR_WIDTH-1:2];
      fifo_tgt_q[wr_ptr_q] <= upd_target;
      fifo_tkn_q[wr_ptr_q] <= upd_taken;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_req) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q;
    rdata_d         = rdata_q;
    pop             = 1'b0;
    busy            = 1'b0;
    tbl_re          = 1'b0;
    tbl_index       = '0;
    tbl_btb_we      = 1'b0;
    tbl_btb_valid   = 1'b0;
    tbl_btb_tag     = '0;
    tbl_btb_target  = '0;
    tbl_pht_we      = 1'b0;
    tbl_pht_counter = '0;

    case (state_q)
      S_INIT: begin
        // Busy drops while the last entry is written so fetch may look up
        // from the very next cycle.
        busy            = !sweep_last;
        tbl_btb_we      = 1'b1;
        tbl_pht_we      = 1'b1;
        tbl_pht_counter = 2'b01;
        tbl_index       = sweep_q;
        sweep_d         = sweep_q + IDX_ONE;
        if (sweep_last) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!fifo_empty) state_d = S_READ;
      end
      S_READ: begin
        if (!fetch_lookup) begin
          tbl_re    = 1'b1;
          tbl_index = head_index;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        rdata_d = tbl_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!fetch_lookup) begin
          tbl_pht_we      = 1'b1;
          tbl_pht_counter = ctr_next;
          tbl_index       = head_index;
          tbl_btb_we      = head_taken;
          if (head_taken) begin
            tbl_btb_valid  = 1'b1;
            tbl_btb_tag    = head_tag;
            tbl_btb_target = head_target;
          end
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (clear_req) begin
      state_d = S_INIT;
      sweep_d = '0;
    end

    // Outputs are gated by reset itself so an assertion mid-operation
    // suppresses the strobe in the same cycle, not at the next edge.
    if (!rstn) begin
      pop             = 1'b0;
      busy            = 1'b1;
      tbl_re          = 1'b0;
      tbl_index       = '0;
      tbl_btb_we      = 1'b0;
      tbl_btb_valid   = 1'b0;
      tbl_btb_tag     = '0;
      tbl_btb_target  = '0;
      tbl_pht_we      = 1'b0;
      tbl_pht_counter = '0;
    end
  end

`ifdef BP_UPDATE_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_update_count     <= '0;
      stat_mispredict_count <= '0;
    end else begin
      if (pop)                     stat_update_count     <= stat_update_count + 32'd1;
      if (push && upd_mispredicted) stat_mispredict_count <= stat_mispredict_count + 32'd1;
    end
  end
`else
  logic unused_mispredicted;
  assign unused_mispredicted = upd_mispredicted;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bp_update_ctrl
//
// Directed bench for bp_update_ctrl with default parameters (32-bit PC,
// 64-entry tables, 4-deep queue). Expected table accesses are queued as the
// stimulus is issued; a monitor pops one entry per observed table strobe.
// A small PHT memory answers reads so counter sequences follow real writes.
// -----------------------------------------------------------------------------
module tb_bp_update_ctrl;

  typedef struct packed {
    logic        re;
    logic        bwe;
    logic        pwe;
    logic [5:0]  idx;
    logic        bval;
    logic [23:0] tag;
    logic [31:0] tgt;
    logic [1:0]  ctr;
  } txn_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clear_req;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredicted;
  logic        fetch_lookup;
  logic        busy;
  logic        tbl_re;
  logic [1:0]  tbl_rdata;
  logic [5:0]  tbl_index;
  logic        tbl_btb_we;
  logic        tbl_btb_valid;
  logic [23:0] tbl_btb_tag;
  logic [31:0] tbl_btb_target;
  logic        tbl_pht_we;
  logic [1:0]  tbl_pht_counter;
`ifdef BP_UPDATE_STATS_EN
  logic [31:0] stat_update_count;
  logic [31:0] stat_mispredict_count;
`endif

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];

  logic [1:0] pht_mem [64];
  logic       pl_en = 1'b0;
  logic [5:0] pl_idx = '0;
  logic [1:0] pl_val = '0;

  always #5 clk = ~clk;

  bp_update_ctrl #(
    .ADDR_WIDTH (32),
    .INDEX_WIDTH(6),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .clear_req       (clear_req),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_mispredicted(upd_mispredicted),
    .fetch_lookup    (fetch_lookup),
    .busy            (busy),
    .tbl_re          (tbl_re),
    .tbl_rdata       (tbl_rdata),
    .tbl_index       (tbl_index),
    .tbl_btb_we      (tbl_btb_we),
    .tbl_btb_valid   (tbl_btb_valid),
    .tbl_btb_tag     (tbl_btb_tag),
    .tbl_btb_target  (tbl_btb_target),
`ifdef BP_UPDATE_STATS_EN
    .stat_update_count    (stat_update_count),
    .stat_mispredict_count(stat_mispredict_count),
`endif
    .tbl_pht_we      (tbl_pht_we),
    .tbl_pht_counter (tbl_pht_counter)
  );

  // PHT storage model: writes land at the edge, reads return the next cycle.
  always @(posedge clk) begin
    if (tbl_pht_we) pht_mem[tbl_index] <= tbl_pht_counter;
    if (pl_en)      pht_mem[pl_idx]    <= pl_val;
    if (tbl_re)     tbl_rdata          <= pht_mem[tbl_index];
  end

  // Monitor: every table strobe must match the oldest expected access.
  initial begin
    txn_t act;
    txn_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && (tbl_re || tbl_btb_we || tbl_pht_we)) begin
        act      = '0;
        act.re   = tbl_re;
        act.bwe  = tbl_btb_we;
        act.pwe  = tbl_pht_we;
        act.idx  = tbl_index;
        act.bval = tbl_btb_valid;
        act.tag  = tbl_btb_tag;
        act.tgt  = tbl_btb_target;
        act.ctr  = tbl_pht_we ? tbl_pht_counter : 2'b00;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got %h with nothing expected", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL table_access: got %h expected %h", act, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input logic [5:0] idx);
    txn_t t;
    t     = '0;
    t.re  = 1'b1;
    t.idx = idx;
    exp_q.push_back(t);
  endtask

  task automatic exp_wr(input logic [5:0] idx, input logic [1:0] ctr, input logic tk,
                        input logic [23:0] tag, input logic [31:0] tgt);
    txn_t t;
    t     = '0;
    t.pwe = 1'b1;
    t.idx = idx;
    t.ctr = ctr;
    if (tk) begin
      t.bwe  = 1'b1;
      t.bval = 1'b1;
      t.tag  = tag;
      t.tgt  = tgt;
    end
    exp_q.push_back(t);
  endtask

  task automatic exp_sweep();
    txn_t t;
    for (int i = 0; i < 64; i++) begin
      t     = '0;
      t.bwe = 1'b1;
      t.pwe = 1'b1;
      t.idx = 6'(i);
      t.ctr = 2'b01;
      exp_q.push_back(t);
    end
  endtask

  // Called at +1 of the first INIT cycle; returns at +1 of the first IDLE+1 cycle.
  task automatic check_sweep();
    for (int k = 0; k < 64; k++) begin
      #2;
      chk("busy_sweep", busy, (k != 63));
      chk("ready_sweep", upd_ready, 1'b0);
      tick();
    end
    #2;
    chk("ready_after_sweep", upd_ready, 1'b1);
    chk("busy_after_sweep", busy, 1'b0);
    tick();
  endtask

  task automatic push_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic mis);
    int unsigned n;
    n                = 0;
    upd_valid        = 1'b1;
    upd_pc           = pc;
    upd_taken        = tk;
    upd_target       = tgt;
    upd_mispredicted = mis;
    #1;
    while (!upd_ready && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!upd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: upd_ready stayed 0 for pc %h", pc);
    end else begin
      @(posedge clk);
    end
    #1;
    upd_valid        = 1'b0;
    upd_mispredicted = 1'b0;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [1:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    tick();
    pl_en  = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    tick();
    tick();
  endtask

  task automatic chk_no_strobe(input string name);
    chk(name, {tbl_re, tbl_btb_we, tbl_pht_we}, 3'b000);
  endtask

  initial begin
    rstn             = 1'b0;
    clear_req        = 1'b0;
    upd_valid        = 1'b0;
    upd_pc           = '0;
    upd_taken        = 1'b0;
    upd_target       = '0;
    upd_mispredicted = 1'b0;
    fetch_lookup     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready", upd_ready, 1'b0);
    chk_no_strobe("rst_strobes");
    chk("rst_index", tbl_index, 6'd0);
    chk("rst_counter", tbl_pht_counter, 2'b00);

    exp_sweep();
    tick();
    rstn = 1'b1;
    check_sweep();

    // A: taken, counter 01 -> 10, BTB filled; best-case 4-cycle timing
    exp_rd(6'd4);
    exp_wr(6'd4, 2'b10, 1'b1, 24'h000010, 32'h0000_2000);
    push_upd(32'h0000_1010, 1'b1, 32'h0000_2000, 1'b0);
    #2; chk_no_strobe("a_idle");
    tick(); #2; chk("a_read_re", tbl_re, 1'b1);
    tick(); #2; chk_no_strobe("a_wait");
    tick(); #2; chk("a_write_we", tbl_pht_we, 1'b1);
    tick();
    wait_drain();

    // B: not-taken with counter 00 saturates, no BTB write
    preload(6'd8, 2'b00);
    exp_rd(6'd8);
    exp_wr(6'd8, 2'b00, 1'b0, 24'h0, 32'h0);
    push_upd(32'h0000_0020, 1'b0, 32'h0000_0000, 1'b1);
    wait_drain();

    // C: taken with counter 11 saturates
    preload(6'd12, 2'b11);
    exp_rd(6'd12);
    exp_wr(6'd12, 2'b11, 1'b1, 24'h000030, 32'h0000_4444);
    push_upd(32'h0000_3030, 1'b1, 32'h0000_4444, 1'b0);
    wait_drain();

    // D: fetch owns the port in READ then in WRITE
    exp_rd(6'd1);
    exp_wr(6'd1, 2'b10, 1'b1, 24'h000001, 32'h0000_8000);
    push_upd(32'h0000_0104, 1'b1, 32'h0000_8000, 1'b0);
    fetch_lookup = 1'b1;
    #2; chk_no_strobe("d_idle_fetch");
    for (int i = 0; i < 3; i++) begin
      tick(); #2; chk_no_strobe("d_read_stall");
    end
    tick(); fetch_lookup = 1'b0;
    #2; chk("d_read_re", tbl_re, 1'b1);
    tick(); fetch_lookup = 1'b1;
    #2; chk_no_strobe("d_wait");
    for (int i = 0; i < 3; i++) begin
      tick(); #2; chk_no_strobe("d_write_stall");
    end
    tick(); fetch_lookup = 1'b0;
    #2; chk("d_write_we", tbl_pht_we, 1'b1);
    tick();
    wait_drain();

    // E: five back-to-back updates, two to index 0 (01 -> 10 -> 11)
    exp_rd(6'd0);  exp_wr(6'd0,  2'b10, 1'b1, 24'h000002, 32'h0000_0100);
    exp_rd(6'd0);  exp_wr(6'd0,  2'b11, 1'b1, 24'h000002, 32'h0000_0104);
    exp_rd(6'd5);  exp_wr(6'd5,  2'b00, 1'b0, 24'h0,      32'h0);
    exp_rd(6'd6);  exp_wr(6'd6,  2'b10, 1'b1, 24'h000000, 32'hABCD_0000);
    exp_rd(6'h1E); exp_wr(6'h1E, 2'b10, 1'b1, 24'h123456, 32'h0000_0040);
    fetch_lookup = 1'b1;
    push_upd(32'h0000_0200, 1'b1, 32'h0000_0100, 1'b0);
    push_upd(32'h0000_0200, 1'b1, 32'h0000_0104, 1'b0);
    push_upd(32'h0000_0A14, 1'b0, 32'h0000_0000, 1'b1);
    push_upd(32'h0000_0018, 1'b1, 32'hABCD_0000, 1'b0);
    #2;
    chk("e_ready_full", upd_ready, 1'b0);
    fetch_lookup = 1'b0;
    push_upd(32'h1234_5678, 1'b1, 32'h0000_0040, 1'b0);
    wait_drain();

    // F: clear in WAIT with 3 queued; concurrent push is dropped
    exp_rd(6'h10);
    fetch_lookup = 1'b1;
    push_upd(32'h0000_0040, 1'b1, 32'h0000_0500, 1'b1);
    push_upd(32'h0000_0044, 1'b1, 32'h0000_0600, 1'b0);
    push_upd(32'h0000_0048, 1'b0, 32'h0000_0000, 1'b0);
    exp_sweep();
    fetch_lookup = 1'b0;
    #2; chk("f_read_re", tbl_re, 1'b1);
    tick();
    clear_req        = 1'b1;
    upd_valid        = 1'b1;
    upd_pc           = 32'h0000_004C;
    upd_taken        = 1'b1;
    upd_target       = 32'h0000_0700;
    upd_mispredicted = 1'b1;
    #2;
    chk_no_strobe("f_wait_clear");
    tick();
    clear_req        = 1'b0;
    upd_valid        = 1'b0;
    upd_mispredicted = 1'b0;
    check_sweep();
    repeat (8) tick();
`ifdef BP_UPDATE_STATS_EN
    chk("stat_updates", stat_update_count, 32'd9);
    chk("stat_mispredicts", stat_mispredict_count, 32'd3);
`endif

    // Tables re-initialised: index 4 is back at 01, not-taken gives 00
    exp_rd(6'd4);
    exp_wr(6'd4, 2'b00, 1'b0, 24'h0, 32'h0);
    push_upd(32'h0000_1010, 1'b0, 32'h0000_0000, 1'b0);
    wait_drain();

    // Reset asserted while a read is about to issue suppresses it at once
    fetch_lookup = 1'b1;
    push_upd(32'h0000_2020, 1'b1, 32'h0000_0900, 1'b0);
    tick();
    fetch_lookup = 1'b0;
    rstn         = 1'b0;
    #2;
    chk_no_strobe("midop_reset_strobes");
    chk("midop_reset_busy", busy, 1'b1);
    chk("midop_reset_ready", upd_ready, 1'b0);
    repeat (2) tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
